// File: rtl/riscv_fetch_req_ctrl.sv
// riscv_fetch_req_ctrl
//   Instruction-fetch request controller. Issues word-aligned requests to
//   instruction memory, keeps at most one transaction outstanding, pushes
//   responses into the fetch FIFO with zero latency and handles branch
//   redirects, including responses that are still in flight when a branch
//   arrives.
//
//   Optional feature macro: FETCH_STALL_CNT_EN
//     defined   -> stall_cnt_o counts request cycles without a grant
//                  (saturating, cleared by branch_i)
//     undefined -> stall_cnt_o tied to zero, no counter logic
//
//   The memory and FIFO handshakes are combinational by nature: the request,
//   the FIFO push and the flush strobe respond to inputs in the same cycle.
module riscv_fetch_req_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h1C00_8080,
    localparam int unsigned ADDR_W   = 32,
    localparam int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,

    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [ADDR_W-1:0] instr_rdata_i,

    output logic              fifo_valid_o,
    output logic [ADDR_W-1:0] fifo_addr_o,
    output logic [ADDR_W-1:0] fifo_rdata_o,
    input  logic              fifo_ready_i,
    output logic              fifo_clear_o,

    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_GNT     = 2'd1,
        WAIT_RVALID  = 2'd2,
        WAIT_ABORTED = 2'd3
    } state_e;

    state_e            state_q;
    state_e            state_d;

    // Word address of the next (or currently requested) fetch.
    logic [ADDR_W-1:0] fetch_addr_q;
    // Full address of the word whose response is outstanding.
    logic [ADDR_W-1:0] resp_addr_q;
    // Low address bits carried by the first word after reset or branch.
    logic [1:0]        first_lo_q;

    logic              can_req;
    logic              gnt_fire;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_lo;

    // A branch redirects the request address in the very cycle it arrives.
    assign can_req      = req_i & fifo_ready_i;
    assign req_addr     = branch_i ? {branch_addr_i[ADDR_W-1:2], 2'b00} : fetch_addr_q;
    assign req_lo       = branch_i ? branch_addr_i[1:0] : first_lo_q;
    assign gnt_fire     = instr_req_o & instr_gnt_i;

    assign instr_addr_o = req_addr;
    assign fifo_addr_o  = resp_addr_q;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_clear_o = rst_n & branch_i;
    assign busy_o       = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, memory request and FIFO push decode.
    always_comb begin
        state_d      = state_q;
        instr_req_o  = 1'b0;
        fifo_valid_o = 1'b0;

        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (can_req) begin
                        instr_req_o = 1'b1;
                        state_d     = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end

                WAIT_GNT: begin
                    instr_req_o = 1'b1;
                    if (instr_gnt_i) begin
                        state_d = WAIT_RVALID;
                    end
                end

                WAIT_RVALID, WAIT_ABORTED: begin
                    if (instr_rvalid_i) begin
                        // Aborted or flushed responses are dropped silently.
                        fifo_valid_o = (state_q == WAIT_RVALID) & ~branch_i;
                        if (can_req) begin
                            instr_req_o = 1'b1;
                            state_d     = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (branch_i) begin
                        state_d = WAIT_ABORTED;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Fetch address, response address and first-word low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q <= {BOOT_ADDR[ADDR_W-1:2], 2'b00};
            resp_addr_q  <= BOOT_ADDR;
            first_lo_q   <= BOOT_ADDR[1:0];
        end else if (gnt_fire) begin
            fetch_addr_q <= req_addr + ADDR_W'(4);
            resp_addr_q  <= {req_addr[ADDR_W-1:2], req_lo};
            first_lo_q   <= 2'b00;
        end else if (branch_i) begin
            fetch_addr_q <= req_addr;
            first_lo_q   <= req_lo;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of request cycles that were not granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (branch_i) begin
            stall_cnt_q <= '0;
        end else if (instr_req_o && !instr_gnt_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    // Request addresses are always word aligned.
    a_req_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        instr_req_o |-> (instr_addr_o[1:0] == 2'b00));

    // Nothing is pushed during a flush.
    a_no_push_on_clear: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_valid_o && fifo_clear_o));

    // A pending, ungranted request is held with a stable address unless redirected.
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (instr_req_o && !instr_gnt_i && !branch_i) |=>
            (instr_req_o && (branch_i || $stable(instr_addr_o))));

endmodule
